pc_fetch_unit: RTL and testbench

- Program-counter and fetch-control stage sitting directly upstream of the instruction memory. It drives that memory's byte-address PC input and consumes its combinational halt flag.
- Each cycle it selects the next PC from sequential (PC+4), branch, jump or register-jump sources.
- Supports a debug single-step mode, latches halt and alignment-fault conditions, and counts retired instructions.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/next_pc_sel.sv | 58 +++++
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 tb/tb_pc_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the program-counter / fetch-control stage.
//   fetch_state_t  : RUN (normal fetch) or HALTED (frozen until reset)
//   PC_STEP        : byte distance between consecutive instructions
//   branch_offset  : sign-extended word offset converted to a byte offset
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic {RUN, HALTED} fetch_state_t;

   localparam int unsigned PC_STEP = 4;

   // Instruction immediates count words; the PC counts bytes.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
// Purely combinational next-PC selection: priority mux jr > jump > branch >
// sequential, with all arithmetic done at 32 bits before truncation so the
// PC wraps modulo 2^PC_WIDTH.
// Ports:
//   pc            in   current fetch address
//   branch_taken  in   conditional branch taken
//   branch_imm    in   signed word offset
//   jump          in   J/JAL
//   jump_target   in   26-bit target field
//   jr            in   JR
//   jr_target     in   register value for JR
//   next_pc       out  selected next fetch address
//   pc_plus4      out  pc + 4 (JAL link value)
//   misaligned    out  JR to a non-word-aligned address
// -----------------------------------------------------------------------------
module next_pc_sel
   import fetch_pkg::*;
#(
   parameter int PC_WIDTH = 6
) (
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                branch_taken,
   input  logic [15:0]         branch_imm,
   input  logic                jump,
   input  logic [25:0]         jump_target,
   input  logic                jr,
   input  logic [31:0]         jr_target,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic [PC_WIDTH-1:0] pc_plus4,
   output logic                misaligned
);

   logic [31:0] pc_ext;
   logic [31:0] seq_ext;
   logic [31:0] sel_ext;

   assign pc_ext  = 32'(pc);
   assign seq_ext = pc_ext + 32'(PC_STEP);

   always_comb begin
      // NOTE: default first so every path assigns sel_ext and no latch is inferred.
      sel_ext = seq_ext;
      if (jr) begin
         sel_ext = jr_target;
      end else if (jump) begin
         sel_ext = {seq_ext[31:28], jump_target, 2'b00};
      end else if (branch_taken) begin
         sel_ext = seq_ext + branch_offset(branch_imm);
      end
   end

   assign next_pc    = PC_WIDTH'(sel_ext);
   assign pc_plus4   = PC_WIDTH'(seq_ext);
   assign misaligned = jr && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter and fetch-control stage feeding the instruction memory.
// Advances the PC each enabled cycle, supports single-step debug, latches
// halt and misaligned-JR faults, and counts retired instructions.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   halt_in          halt flag from instruction memory (combinational on pc)
//   step_mode        1 = advance only on step_req
//   step_req         one-cycle step permission
//   branch_taken, branch_imm, jump, jump_target, jr, jr_target
//                    control-flow requests for the current instruction
//   pc               registered fetch address
//   pc_plus4         pc + 4, combinational
//   halted           sticky halt indicator
//   fault            sticky misaligned-JR fault
//   retired          saturating retired-instruction count
// -----------------------------------------------------------------------------
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                   PC_WIDTH  = 6,
   parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
   parameter int                   CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 halt_in,
   input  logic                 step_mode,
   input  logic                 step_req,
   input  logic                 branch_taken,
   input  logic [15:0]          branch_imm,
   input  logic                 jump,
   input  logic [25:0]          jump_target,
   input  logic                 jr,
   input  logic [31:0]          jr_target,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [PC_WIDTH-1:0]  pc_plus4,
   output logic                 halted,
   output logic                 fault,
   output logic [CNT_WIDTH-1:0] retired
);

   fetch_state_t         state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic                 fault_q, fault_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;

   logic [PC_WIDTH-1:0]  next_pc;
   logic                 misaligned;
   logic                 adv;

   next_pc_sel #(.PC_WIDTH(PC_WIDTH)) u_sel (
      .pc           (pc_q),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_target  (jump_target),
      .jr           (jr),
      .jr_target    (jr_target),
      .next_pc      (next_pc),
      .pc_plus4     (pc_plus4),
      .misaligned   (misaligned)
   );

   // halt_in gates adv, so a halting instruction can never advance or retire.
   assign adv = (state_q == RUN) && !halt_in && (!step_mode || step_req);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fault_d   = fault_q;
      retired_d = retired_q;
      if (state_q == RUN) begin
         if (halt_in) begin
            state_d = HALTED;
         end else if (adv) begin
            if (misaligned) begin
               fault_d = 1'b1;
               state_d = HALTED;
            end else begin
               pc_d = next_pc;
               if (retired_q != '1) begin
                  retired_d = retired_q + CNT_WIDTH'(1);
               end
            end
         end
      end
   end

   // NOTE: reset is synchronous here, so it lives inside the clocked block
   // with no reset term in the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         fault_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         pc_q      <= pc_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   assign pc      = pc_q;
   assign halted  = (state_q == HALTED);
   assign fault   = fault_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed stimulus with a scoreboard: each stimulus cycle pushes the
// hand-computed expected state into a queue; a monitor on the falling edge
// pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

   localparam int PC_WIDTH  = 6;
   localparam int CNT_WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 halt_in;
   logic                 step_mode;
   logic                 step_req;
   logic                 branch_taken;
   logic [15:0]          branch_imm;
   logic                 jump;
   logic [25:0]          jump_target;
   logic                 jr;
   logic [31:0]          jr_target;
   logic [PC_WIDTH-1:0]  pc;
   logic [PC_WIDTH-1:0]  pc_plus4;
   logic                 halted;
   logic                 fault;
   logic [CNT_WIDTH-1:0] retired;

   pc_fetch_unit #(
      .PC_WIDTH  (PC_WIDTH),
      .RESET_PC  (6'd0),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .halt_in      (halt_in),
      .step_mode    (step_mode),
      .step_req     (step_req),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_target  (jump_target),
      .jr           (jr),
      .jr_target    (jr_target),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .halted       (halted),
      .fault        (fault),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      string                name;
      logic [PC_WIDTH-1:0]  pc;
      logic                 halted;
      logic                 fault;
      logic [CNT_WIDTH-1:0] retired;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: compare every pending expectation on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({e.name, ".pc"},       32'(pc),       32'(e.pc));
         check({e.name, ".pc_plus4"}, 32'(pc_plus4), 32'(6'(e.pc + 6'd4)));
         check({e.name, ".halted"},   32'(halted),   32'(e.halted));
         check({e.name, ".fault"},    32'(fault),    32'(e.fault));
         check({e.name, ".retired"},  32'(retired),  32'(e.retired));
      end
   end

   task automatic ctl(input logic h, input logic sm, input logic sr,
                      input logic bt, input logic [15:0] imm,
                      input logic j, input logic [25:0] jt,
                      input logic r, input logic [31:0] rt);
      halt_in = h; step_mode = sm; step_req = sr;
      branch_taken = bt; branch_imm = imm;
      jump = j; jump_target = jt; jr = r; jr_target = rt;
   endtask

   task automatic idle();
      ctl(0, 0, 0, 0, 16'd0, 0, 26'd0, 0, 32'd0);
   endtask

   // One clock edge, then queue the state expected after that edge.
   task automatic tick(input string name, input logic [PC_WIDTH-1:0] epc,
                       input logic eh, input logic ef, input logic [CNT_WIDTH-1:0] er);
      exp_t e;
      @(posedge clk);
      #1;
      e.name = name; e.pc = epc; e.halted = eh; e.fault = ef; e.retired = er;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick("reset", 6'd0, 0, 0, 16'd0);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle();

      // Reset and free-run sequence.
      do_reset();
      for (int i = 1; i <= 5; i++) tick("seq", 6'(4 * i), 0, 0, 16'(i));

      // Reach pc=56 via JR, then wrap with branches.
      ctl(0, 0, 0, 0, 16'd0, 0, 26'd0, 1, 32'd56);
      tick("jr56", 6'd56, 0, 0, 16'd6);
      ctl(0, 0, 0, 1, 16'd1, 0, 26'd0, 0, 32'd0);
      tick("br_wrap", 6'd0, 0, 0, 16'd7);
      ctl(0, 0, 0, 1, 16'hFFFE, 0, 26'd0, 0, 32'd0);
      tick("br_neg", 6'd60, 0, 0, 16'd8);
      idle();
      tick("seq_wrap", 6'd0, 0, 0, 16'd9);

      // Priority jr > jump > branch.
      ctl(0, 0, 0, 1, 16'd5, 1, 26'd3, 1, 32'h24);
      tick("prio_jr", 6'd36, 0, 0, 16'd10);
      ctl(0, 0, 0, 0, 16'd0, 1, 26'd3, 0, 32'd0);
      tick("jump", 6'd12, 0, 0, 16'd11);
      ctl(0, 0, 0, 1, 16'd1, 1, 26'd5, 0, 32'd0);
      tick("prio_jump", 6'd20, 0, 0, 16'd12);

      // Misaligned JR at pc=8.
      ctl(0, 0, 0, 0, 16'd0, 0, 26'd0, 1, 32'd8);
      tick("jr8", 6'd8, 0, 0, 16'd13);
      ctl(0, 0, 0, 0, 16'd0, 0, 26'd0, 1, 32'h22);
      tick("misalign", 6'd8, 1, 1, 16'd13);
      ctl(0, 0, 0, 1, 16'd3, 1, 26'd1, 0, 32'd0);
      tick("fault_hold", 6'd8, 1, 1, 16'd13);
      idle();
      tick("fault_hold2", 6'd8, 1, 1, 16'd13);
      do_reset();

      // Halt at pc=16 with retired=4.
      for (int i = 1; i <= 4; i++) tick("pre_halt", 6'(4 * i), 0, 0, 16'(i));
      ctl(1, 0, 0, 0, 16'd0, 1, 26'd2, 0, 32'd0);
      tick("halt", 6'd16, 1, 0, 16'd4);
      ctl(0, 0, 0, 0, 16'd0, 1, 26'd2, 0, 32'd0);
      tick("halt_hold", 6'd16, 1, 0, 16'd4);
      do_reset();

      // Step mode: step_req on cycles 2 and 5 of 6.
      ctl(0, 1, 0, 0, 16'd0, 0, 26'd0, 0, 32'd0);
      tick("step_c1", 6'd0, 0, 0, 16'd0);
      step_req = 1'b1;
      tick("step_c2", 6'd4, 0, 0, 16'd1);
      step_req = 1'b0;
      tick("step_c3", 6'd4, 0, 0, 16'd1);
      tick("step_c4", 6'd4, 0, 0, 16'd1);
      step_req = 1'b1;
      tick("step_c5", 6'd8, 0, 0, 16'd2);
      step_req = 1'b0;
      tick("step_c6", 6'd8, 0, 0, 16'd2);
      ctl(1, 1, 1, 0, 16'd0, 0, 26'd0, 0, 32'd0);
      tick("step_halt", 6'd8, 1, 0, 16'd2);
      do_reset();

      // step_req ignored outside step mode: exactly one advance per cycle.
      ctl(0, 0, 1, 0, 16'd0, 0, 26'd0, 0, 32'd0);
      tick("req_free", 6'd4, 0, 0, 16'd1);
      do_reset();

      // Counter saturation: 65535 advances leave pc at 60, then one more holds count.
      idle();
      repeat (65534) @(posedge clk);
      tick("sat_reach", 6'd60, 0, 0, 16'hFFFF);
      tick("sat_hold", 6'd0, 0, 0, 16'hFFFF);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
